tx_frame_arbiter: RTL and testbench

- Packet-granular arbiter sharing the single 32-bit AXI-Stream transmit path between the ARP send stream and the IP send stream.
- Once a frame is granted it owns the path until its tlast beat has been accepted, so frames never interleave.
- Inserts a programmable idle gap between frames and keeps per-source frame counters.
- Sits between the ARP/IP send engines and the 32-to-8 width converter.

---
 rtl/tx_frame_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_tx_frame_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter
// Packet-granular arbiter that shares one 32-bit AXI-Stream transmit path
// between the ARP send stream and the IP send stream. A granted frame owns
// the path until its tlast beat is accepted, so frames never interleave.
// After every frame a programmable idle gap is forced. Per-source frame
// counters track completed frames.
//
// Ports:
//   clk, reset_n                 clock and synchronous active-low reset
//   arp_t*_in / arp_tready_out   ARP AXI-Stream slave side
//   ip_t*_in  / ip_tready_out    IP AXI-Stream slave side
//   axis_t*_out / axis_tready_in arbitrated AXI-Stream master side
//   grant_out                    one-hot owner (bit0 ARP, bit1 IP), 00 idle/gap
//   arp_frame_cnt_out            ARP frames completed (wrapping)
//   ip_frame_cnt_out             IP frames completed (wrapping)
module tx_frame_arbiter #(
    parameter bit ARP_PRIORITY = 1'b1,
    parameter int IFG_CYCLES   = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      arp_tdata_in,
    input  logic [3:0]       arp_tkeep_in,
    input  logic             arp_tvalid_in,
    input  logic             arp_tlast_in,
    output logic             arp_tready_out,
    input  logic [31:0]      ip_tdata_in,
    input  logic [3:0]       ip_tkeep_in,
    input  logic             ip_tvalid_in,
    input  logic             ip_tlast_in,
    output logic             ip_tready_out,
    output logic [31:0]      axis_tdata_out,
    output logic [3:0]       axis_tkeep_out,
    output logic             axis_tvalid_out,
    output logic             axis_tlast_out,
    input  logic             axis_tready_in,
    output logic [1:0]       grant_out,
    output logic [CNT_W-1:0] arp_frame_cnt_out,
    output logic [CNT_W-1:0] ip_frame_cnt_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARP_XFER = 2'd1,
        IP_XFER  = 2'd2,
        GAP      = 2'd3
    } state_t;

    // Gap counter runs 0 .. IFG_CYCLES-1 while in GAP.
    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST =
        (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : {GAP_W{1'b0}};
    // With a zero gap a finished frame returns straight to IDLE.
    localparam state_t DONE_STATE = (IFG_CYCLES > 0) ? GAP : IDLE;

    state_t             state_r;
    state_t             next_state_s;
    logic               rr_ip_r;      // 1: IP is favoured on a tie (round-robin)
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [CNT_W-1:0]   arp_cnt_r;
    logic [CNT_W-1:0]   ip_cnt_r;
    logic               arp_done_s;
    logic               ip_done_s;

    assign arp_frame_cnt_out = arp_cnt_r;
    assign ip_frame_cnt_out  = ip_cnt_r;

    // Next-state decode and zero-latency datapath mux for the current owner.
    always_comb begin
        next_state_s    = state_r;
        axis_tdata_out  = 32'd0;
        axis_tkeep_out  = 4'd0;
        axis_tvalid_out = 1'b0;
        axis_tlast_out  = 1'b0;
        arp_tready_out  = 1'b0;
        ip_tready_out   = 1'b0;
        grant_out       = 2'b00;
        arp_done_s      = 1'b0;
        ip_done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                // Requests are only sampled here; no beat moves in this cycle.
                if (arp_tvalid_in && ip_tvalid_in) begin
                    if ((ARP_PRIORITY == 1'b1) || !rr_ip_r) begin
                        next_state_s = ARP_XFER;
                    end else begin
                        next_state_s = IP_XFER;
                    end
                end else if (arp_tvalid_in) begin
                    next_state_s = ARP_XFER;
                end else if (ip_tvalid_in) begin
                    next_state_s = IP_XFER;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ARP_XFER: begin
                axis_tdata_out  = arp_tdata_in;
                axis_tkeep_out  = arp_tkeep_in;
                axis_tvalid_out = arp_tvalid_in;
                axis_tlast_out  = arp_tlast_in;
                arp_tready_out  = axis_tready_in;
                grant_out       = 2'b01;
                arp_done_s      = arp_tvalid_in & axis_tready_in & arp_tlast_in;
                if (arp_done_s) begin
                    next_state_s = DONE_STATE;
                end else begin
                    next_state_s = ARP_XFER;
                end
            end
            IP_XFER: begin
                axis_tdata_out  = ip_tdata_in;
                axis_tkeep_out  = ip_tkeep_in;
                axis_tvalid_out = ip_tvalid_in;
                axis_tlast_out  = ip_tlast_in;
                ip_tready_out   = axis_tready_in;
                grant_out       = 2'b10;
                ip_done_s       = ip_tvalid_in & axis_tready_in & ip_tlast_in;
                if (ip_done_s) begin
                    next_state_s = DONE_STATE;
                end else begin
                    next_state_s = IP_XFER;
                end
            end
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = GAP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Inter-frame gap counter, cleared whenever the FSM is outside GAP.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gap_cnt_r <= {GAP_W{1'b0}};
        end else if (state_r == GAP) begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
        end else begin
            gap_cnt_r <= {GAP_W{1'b0}};
        end
    end

    // Round-robin pointer: after a frame the other source is favoured.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ip_r <= 1'b0;
        end else if (arp_done_s) begin
            rr_ip_r <= 1'b1;
        end else if (ip_done_s) begin
            rr_ip_r <= 1'b0;
        end else begin
            rr_ip_r <= rr_ip_r;
        end
    end

    // Per-source completed-frame counters (wrap naturally).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            arp_cnt_r <= {CNT_W{1'b0}};
            ip_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (arp_done_s) begin
                arp_cnt_r <= arp_cnt_r + CNT_W'(1);
            end
            if (ip_done_s) begin
                ip_cnt_r <= ip_cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
module tb_tx_frame_arbiter;

    logic        clk;
    logic        reset_n;
    logic [31:0] arp_tdata;
    logic [3:0]  arp_tkeep;
    logic        arp_tvalid;
    logic        arp_tlast;
    logic [31:0] ip_tdata;
    logic [3:0]  ip_tkeep;
    logic        ip_tvalid;
    logic        ip_tlast;
    logic        axis_tready;

    // Instance A: ARP priority, gap 2
    logic        a_arp_rdy, a_ip_rdy, a_tvalid, a_tlast;
    logic [31:0] a_tdata;
    logic [3:0]  a_tkeep;
    logic [1:0]  a_grant;
    logic [15:0] a_arp_cnt, a_ip_cnt;
    // Instance B: round-robin, gap 2
    logic        b_arp_rdy, b_ip_rdy, b_tvalid, b_tlast;
    logic [31:0] b_tdata;
    logic [3:0]  b_tkeep;
    logic [1:0]  b_grant;
    logic [15:0] b_arp_cnt, b_ip_cnt;
    // Instance C: ARP priority, no gap, 4-bit counters
    logic        c_arp_rdy, c_ip_rdy, c_tvalid, c_tlast;
    logic [31:0] c_tdata;
    logic [3:0]  c_tkeep;
    logic [1:0]  c_grant;
    logic [3:0]  c_arp_cnt, c_ip_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    tx_frame_arbiter #(.ARP_PRIORITY(1'b1), .IFG_CYCLES(2), .CNT_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .arp_tdata_in(arp_tdata), .arp_tkeep_in(arp_tkeep), .arp_tvalid_in(arp_tvalid),
        .arp_tlast_in(arp_tlast), .arp_tready_out(a_arp_rdy),
        .ip_tdata_in(ip_tdata), .ip_tkeep_in(ip_tkeep), .ip_tvalid_in(ip_tvalid),
        .ip_tlast_in(ip_tlast), .ip_tready_out(a_ip_rdy),
        .axis_tdata_out(a_tdata), .axis_tkeep_out(a_tkeep), .axis_tvalid_out(a_tvalid),
        .axis_tlast_out(a_tlast), .axis_tready_in(axis_tready), .grant_out(a_grant),
        .arp_frame_cnt_out(a_arp_cnt), .ip_frame_cnt_out(a_ip_cnt));

    tx_frame_arbiter #(.ARP_PRIORITY(1'b0), .IFG_CYCLES(2), .CNT_W(16)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .arp_tdata_in(arp_tdata), .arp_tkeep_in(arp_tkeep), .arp_tvalid_in(arp_tvalid),
        .arp_tlast_in(arp_tlast), .arp_tready_out(b_arp_rdy),
        .ip_tdata_in(ip_tdata), .ip_tkeep_in(ip_tkeep), .ip_tvalid_in(ip_tvalid),
        .ip_tlast_in(ip_tlast), .ip_tready_out(b_ip_rdy),
        .axis_tdata_out(b_tdata), .axis_tkeep_out(b_tkeep), .axis_tvalid_out(b_tvalid),
        .axis_tlast_out(b_tlast), .axis_tready_in(axis_tready), .grant_out(b_grant),
        .arp_frame_cnt_out(b_arp_cnt), .ip_frame_cnt_out(b_ip_cnt));

    tx_frame_arbiter #(.ARP_PRIORITY(1'b1), .IFG_CYCLES(0), .CNT_W(4)) dut_c (
        .clk(clk), .reset_n(reset_n),
        .arp_tdata_in(arp_tdata), .arp_tkeep_in(arp_tkeep), .arp_tvalid_in(arp_tvalid),
        .arp_tlast_in(arp_tlast), .arp_tready_out(c_arp_rdy),
        .ip_tdata_in(ip_tdata), .ip_tkeep_in(ip_tkeep), .ip_tvalid_in(ip_tvalid),
        .ip_tlast_in(ip_tlast), .ip_tready_out(c_ip_rdy),
        .axis_tdata_out(c_tdata), .axis_tkeep_out(c_tkeep), .axis_tvalid_out(c_tvalid),
        .axis_tlast_out(c_tlast), .axis_tready_in(axis_tready), .grant_out(c_grant),
        .arp_frame_cnt_out(c_arp_cnt), .ip_frame_cnt_out(c_ip_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        arp_tdata = 32'd0; arp_tkeep = 4'd0; arp_tvalid = 1'b0; arp_tlast = 1'b0;
        ip_tdata  = 32'd0; ip_tkeep  = 4'd0; ip_tvalid  = 1'b0; ip_tlast  = 1'b0;
        axis_tready = 1'b1;
    endtask

    // Returns on a falling edge with every instance in IDLE.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        arp_tvalid = 1'b1; arp_tdata = 32'h12345678; arp_tkeep = 4'hF; arp_tlast = 1'b1;
        ip_tvalid = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({a_tvalid, a_tlast, a_tdata, a_tkeep} !== 38'd0) begin
            n_fail++; $display("FAIL reset_datapath: got %h expected 0", {a_tvalid, a_tlast, a_tdata, a_tkeep});
        end
        n_checks++;
        if ({a_arp_rdy, a_ip_rdy, a_grant} !== 4'd0) begin
            n_fail++; $display("FAIL reset_ready_grant: got %b expected 0000", {a_arp_rdy, a_ip_rdy, a_grant});
        end
        n_checks++;
        if ({a_arp_cnt, a_ip_cnt} !== 32'd0) begin
            n_fail++; $display("FAIL reset_counters: got %h expected 0", {a_arp_cnt, a_ip_cnt});
        end
        n_checks++;
        if ({b_grant, c_grant, c_arp_cnt} !== 8'd0) begin
            n_fail++; $display("FAIL reset_other_inst: got %h expected 0", {b_grant, c_grant, c_arp_cnt});
        end
        idle_inputs();
    endtask

    task automatic test_arp_only();
        do_reset();
        arp_tvalid = 1'b1; arp_tdata = 32'h11111111; arp_tkeep = 4'hF; arp_tlast = 1'b0;
        #1;
        n_checks++;
        if ({a_tvalid, a_grant, a_arp_rdy} !== 4'b0000) begin
            n_fail++; $display("FAIL arp_idle_cycle: got %b expected 0000", {a_tvalid, a_grant, a_arp_rdy});
        end
        @(negedge clk); #1;
        n_checks++;
        if ({a_grant, a_tvalid, a_tlast, a_arp_rdy, a_ip_rdy, a_tdata} !== {2'b01, 4'b1010, 32'h11111111}) begin
            n_fail++; $display("FAIL arp_beat1: got %h expected %h", {a_grant, a_tvalid, a_tlast, a_arp_rdy, a_ip_rdy, a_tdata}, {2'b01, 4'b1010, 32'h11111111});
        end
        @(negedge clk);
        arp_tdata = 32'h22222222;
        #1;
        n_checks++;
        if ({a_grant, a_tdata, a_tlast} !== {2'b01, 32'h22222222, 1'b0}) begin
            n_fail++; $display("FAIL arp_beat2: got %h expected %h", {a_grant, a_tdata, a_tlast}, {2'b01, 32'h22222222, 1'b0});
        end
        @(negedge clk);
        arp_tdata = 32'h33333333; arp_tkeep = 4'h3; arp_tlast = 1'b1;
        #1;
        n_checks++;
        if ({a_grant, a_tdata, a_tkeep, a_tlast} !== {2'b01, 32'h33333333, 4'h3, 1'b1}) begin
            n_fail++; $display("FAIL arp_beat3: got %h expected %h", {a_grant, a_tdata, a_tkeep, a_tlast}, {2'b01, 32'h33333333, 4'h3, 1'b1});
        end
        // Second, single-beat frame kept pending through the gap.
        @(negedge clk);
        arp_tdata = 32'h44444444; arp_tkeep = 4'hF; arp_tlast = 1'b1;
        #1;
        n_checks++;
        if (a_arp_cnt !== 16'd1) begin
            n_fail++; $display("FAIL arp_cnt_after_frame: got %0d expected 1", a_arp_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge clk); #1;
            end
            n_checks++;
            if ({a_tvalid, a_grant} !== 3'b000) begin
                n_fail++; $display("FAIL arp_gap_cycle%0d: got %b expected 000", i, {a_tvalid, a_grant});
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if ({a_tvalid, a_grant, a_tdata} !== {1'b1, 2'b01, 32'h44444444}) begin
            n_fail++; $display("FAIL arp_after_gap: got %h expected %h", {a_tvalid, a_grant, a_tdata}, {1'b1, 2'b01, 32'h44444444});
        end
        @(negedge clk);
        arp_tvalid = 1'b0;
        #1;
        n_checks++;
        if ({a_arp_cnt, a_grant} !== {16'd2, 2'b00}) begin
            n_fail++; $display("FAIL arp_single_beat_cnt: got %h expected %h", {a_arp_cnt, a_grant}, {16'd2, 2'b00});
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        arp_tvalid = 1'b1; arp_tdata = 32'hA0000001; arp_tkeep = 4'hF; arp_tlast = 1'b0;
        ip_tvalid  = 1'b1; ip_tdata  = 32'hB0000001; ip_tkeep  = 4'hF; ip_tlast  = 1'b0;
        #1;
        n_checks++;
        if (b_grant !== 2'b00) begin
            n_fail++; $display("FAIL rr_idle: got %b expected 00", b_grant);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({b_grant, b_arp_rdy, b_ip_rdy, b_tdata} !== {2'b01, 2'b10, 32'hA0000001}) begin
            n_fail++; $display("FAIL rr_first_arp: got %h expected %h", {b_grant, b_arp_rdy, b_ip_rdy, b_tdata}, {2'b01, 2'b10, 32'hA0000001});
        end
        @(negedge clk);
        arp_tdata = 32'hA0000002; arp_tlast = 1'b1;
        #1;
        n_checks++;
        if ({b_grant, b_tdata, b_tlast} !== {2'b01, 32'hA0000002, 1'b1}) begin
            n_fail++; $display("FAIL rr_arp_last: got %h expected %h", {b_grant, b_tdata, b_tlast}, {2'b01, 32'hA0000002, 1'b1});
        end
        @(negedge clk);
        arp_tdata = 32'hA0000003; arp_tlast = 1'b1;
        #1;
        n_checks++;
        if ({b_grant, b_tvalid} !== 3'b000) begin
            n_fail++; $display("FAIL rr_gap: got %b expected 000", {b_grant, b_tvalid});
        end
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({b_grant, b_arp_rdy, b_ip_rdy, b_tdata} !== {2'b10, 2'b01, 32'hB0000001}) begin
            n_fail++; $display("FAIL rr_ip_second: got %h expected %h", {b_grant, b_arp_rdy, b_ip_rdy, b_tdata}, {2'b10, 2'b01, 32'hB0000001});
        end
        n_checks++;
        if (a_grant !== 2'b01) begin
            n_fail++; $display("FAIL prio_tie_arp: got %b expected 01", a_grant);
        end
        @(negedge clk);
        ip_tdata = 32'hB0000002; ip_tlast = 1'b1;
        #1;
        n_checks++;
        if ({b_grant, b_tdata, b_tlast} !== {2'b10, 32'hB0000002, 1'b1}) begin
            n_fail++; $display("FAIL rr_ip_last: got %h expected %h", {b_grant, b_tdata, b_tlast}, {2'b10, 32'hB0000002, 1'b1});
        end
        @(negedge clk);
        ip_tvalid = 1'b0;
        #1;
        n_checks++;
        if ({b_grant, b_ip_cnt} !== {2'b00, 16'd1}) begin
            n_fail++; $display("FAIL rr_ip_cnt: got %h expected %h", {b_grant, b_ip_cnt}, {2'b00, 16'd1});
        end
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({b_grant, b_tdata} !== {2'b01, 32'hA0000003}) begin
            n_fail++; $display("FAIL rr_arp_third: got %h expected %h", {b_grant, b_tdata}, {2'b01, 32'hA0000003});
        end
        @(negedge clk);
        arp_tvalid = 1'b0;
        #1;
        n_checks++;
        if (b_arp_cnt !== 16'd2) begin
            n_fail++; $display("FAIL rr_arp_cnt: got %0d expected 2", b_arp_cnt);
        end
    endtask

    task automatic test_priority_no_preempt();
        do_reset();
        ip_tvalid = 1'b1; ip_tdata = 32'hC0000001; ip_tkeep = 4'hF; ip_tlast = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ip_tdata = 32'hC0000001 + 32'(k);
            ip_tlast = (k == 2);
            arp_tvalid = 1'b1; arp_tdata = 32'hD0000001; arp_tkeep = 4'hF; arp_tlast = 1'b1;
            #1;
            n_checks++;
            if ({a_grant, a_ip_rdy, a_arp_rdy, a_tdata} !== {2'b10, 2'b10, 32'hC0000001 + 32'(k)}) begin
                n_fail++; $display("FAIL noprempt_beat%0d: got %h expected %h", k, {a_grant, a_ip_rdy, a_arp_rdy, a_tdata}, {2'b10, 2'b10, 32'hC0000001 + 32'(k)});
            end
        end
        @(negedge clk);
        ip_tvalid = 1'b0;
        #1;
        n_checks++;
        if ({a_grant, a_ip_cnt} !== {2'b00, 16'd1}) begin
            n_fail++; $display("FAIL noprempt_ip_cnt: got %h expected %h", {a_grant, a_ip_cnt}, {2'b00, 16'd1});
        end
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({a_grant, a_tdata} !== {2'b01, 32'hD0000001}) begin
            n_fail++; $display("FAIL noprempt_arp_follows: got %h expected %h", {a_grant, a_tdata}, {2'b01, 32'hD0000001});
        end
        @(negedge clk);
        arp_tvalid = 1'b0;
        #1;
        n_checks++;
        if (a_arp_cnt !== 16'd1) begin
            n_fail++; $display("FAIL noprempt_arp_cnt: got %0d expected 1", a_arp_cnt);
        end
    endtask

    task automatic test_stall();
        int k;
        int cycles;
        do_reset();
        k = 0;
        cycles = 0;
        ip_tvalid = 1'b1; ip_tdata = 32'hE0000000; ip_tkeep = 4'hF; ip_tlast = 1'b0;
        #1;
        n_checks++;
        if (a_grant !== 2'b00) begin
            n_fail++; $display("FAIL stall_idle: got %b expected 00", a_grant);
        end
        while (k < 64 && cycles < 1000) begin
            @(negedge clk);
            cycles++;
            axis_tready = 1'($urandom_range(1, 0));
            ip_tdata = 32'hE0000000 + 32'(k);
            ip_tlast = (k == 63);
            #1;
            n_checks++;
            if ({a_grant, a_tvalid, a_tlast, a_ip_rdy, a_tdata} !== {2'b10, 1'b1, ip_tlast, axis_tready, 32'hE0000000 + 32'(k)}) begin
                n_fail++; $display("FAIL stall_beat%0d: got %h expected %h", k, {a_grant, a_tvalid, a_tlast, a_ip_rdy, a_tdata}, {2'b10, 1'b1, ip_tlast, axis_tready, 32'hE0000000 + 32'(k)});
            end
            if (axis_tready) begin
                k++;
            end
        end
        n_checks++;
        if (k != 64) begin
            n_fail++; $display("FAIL stall_timeout: got %0d beats expected 64", k);
        end
        @(negedge clk);
        ip_tvalid = 1'b0; ip_tlast = 1'b0; axis_tready = 1'b1;
        #1;
        n_checks++;
        if ({a_grant, a_ip_cnt} !== {2'b00, 16'd1}) begin
            n_fail++; $display("FAIL stall_ip_cnt: got %h expected %h", {a_grant, a_ip_cnt}, {2'b00, 16'd1});
        end
    endtask

    // Runs straight after test_stall, so instance A holds ip count 1 here.
    task automatic test_reset_mid_frame();
        repeat (2) @(negedge clk);
        arp_tvalid = 1'b1; arp_tdata = 32'hF0000001; arp_tkeep = 4'hF; arp_tlast = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if ({a_grant, a_tdata} !== {2'b01, 32'hF0000001}) begin
            n_fail++; $display("FAIL midrst_beat1: got %h expected %h", {a_grant, a_tdata}, {2'b01, 32'hF0000001});
        end
        @(negedge clk);
        arp_tdata = 32'hF0000002;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({a_grant, a_tdata} !== {2'b01, 32'hF0000002}) begin
            n_fail++; $display("FAIL midrst_beat2: got %h expected %h", {a_grant, a_tdata}, {2'b01, 32'hF0000002});
        end
        @(negedge clk);
        reset_n = 1'b1;
        arp_tdata = 32'h90000001; arp_tlast = 1'b0;
        #1;
        n_checks++;
        if ({a_tvalid, a_tlast, a_arp_rdy, a_ip_rdy, a_grant, a_tdata, a_tkeep} !== 42'd0) begin
            n_fail++; $display("FAIL midrst_outputs: got %h expected 0", {a_tvalid, a_tlast, a_arp_rdy, a_ip_rdy, a_grant, a_tdata, a_tkeep});
        end
        n_checks++;
        if ({a_arp_cnt, a_ip_cnt} !== 32'd0) begin
            n_fail++; $display("FAIL midrst_counters: got %h expected 0", {a_arp_cnt, a_ip_cnt});
        end
        @(negedge clk); #1;
        n_checks++;
        if ({a_grant, a_tdata} !== {2'b01, 32'h90000001}) begin
            n_fail++; $display("FAIL midrst_new_beat1: got %h expected %h", {a_grant, a_tdata}, {2'b01, 32'h90000001});
        end
        @(negedge clk);
        arp_tdata = 32'h90000002; arp_tlast = 1'b1;
        #1;
        n_checks++;
        if ({a_grant, a_tdata, a_tlast} !== {2'b01, 32'h90000002, 1'b1}) begin
            n_fail++; $display("FAIL midrst_new_last: got %h expected %h", {a_grant, a_tdata, a_tlast}, {2'b01, 32'h90000002, 1'b1});
        end
        @(negedge clk);
        arp_tvalid = 1'b0; arp_tlast = 1'b0;
        #1;
        n_checks++;
        if (a_arp_cnt !== 16'd1) begin
            n_fail++; $display("FAIL midrst_new_cnt: got %0d expected 1", a_arp_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_g;
        do_reset();
        arp_tvalid = 1'b1; arp_tkeep = 4'hF; arp_tlast = 1'b1;
        for (int i = 0; i < 34; i++) begin
            if (i > 0) begin
                @(negedge clk);
            end
            arp_tdata = 32'(i);
            #1;
            exp_g = ((i % 2) == 1) ? 2'b01 : 2'b00;
            n_checks++;
            if (c_grant !== exp_g) begin
                n_fail++; $display("FAIL wrap_grant%0d: got %b expected %b", i, c_grant, exp_g);
            end
            if (i == 32) begin
                n_checks++;
                if (c_arp_cnt !== 4'd0) begin
                    n_fail++; $display("FAIL wrap_cnt16: got %0d expected 0", c_arp_cnt);
                end
            end
        end
        @(negedge clk);
        arp_tvalid = 1'b0;
        #1;
        n_checks++;
        if (c_arp_cnt !== 4'd1) begin
            n_fail++; $display("FAIL wrap_cnt17: got %0d expected 1", c_arp_cnt);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_arp_only();
        test_round_robin();
        test_priority_no_preempt();
        test_stall();
        test_reset_mid_frame();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
